// File: rtl/riscv_defs.sv
// Shared definitions for the multicycle RISC-V control path: FSM states,
// opcodes, datapath select encodings and ALU_op codes (also used by ALUDecoder).
package riscv_defs;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned IMM_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11
  } state_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I_ALU  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // Branch funct3
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  // result_src encodings
  localparam logic [SEL_W-1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA       = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU_RESULT = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM        = 2'b11;

  // ALU_src_A encodings
  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_REG    = 2'b10;

  // ALU_src_B encodings
  localparam logic [SEL_W-1:0] SRC_B_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

  // ALU_op codes shared with ALUDecoder
  localparam logic [SEL_W-1:0] ADD_ANYWAY = 2'b00;
  localparam logic [SEL_W-1:0] SUB_ANYWAY = 2'b01;
  localparam logic [SEL_W-1:0] R_TYPE     = 2'b10;
  localparam logic [SEL_W-1:0] I_TYPE     = 2'b11;

  // imm_src encodings
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_R)  || (op == OP_I_ALU)  || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath controls.
import riscv_defs::*;

module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_W-1:0]        op,
  input  logic [F3_W-1:0]        f3,
  input  logic                   zero,
  output logic                   PC_write,
  output logic                   adr_src,
  output logic                   mem_write,
  output logic                   IR_write,
  output logic                   reg_write,
  output logic [SEL_W-1:0]       result_src,
  output logic [SEL_W-1:0]       ALU_src_A,
  output logic [SEL_W-1:0]       ALU_src_B,
  output logic [SEL_W-1:0]       ALU_op,
  output logic [IMM_W-1:0]       imm_src,
  output logic                   illegal_op
);

  state_t state;
  state_t state_next;

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state sequencing; unknown states recover to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I_ALU:     state_next = S_EXEC_I;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADR:   state_next = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = S_FETCH;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL:       state_next = S_ALU_WB;
      S_LUI:       state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // Moore control outputs (branch PC_write also looks at f3/zero); enables held low in reset
  always_comb begin
    PC_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    IR_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = RES_ALU_OUT;
    ALU_src_A  = SRC_A_PC;
    ALU_src_B  = SRC_B_REG;
    ALU_op     = ADD_ANYWAY;
    case (state)
      S_FETCH: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        ALU_src_B  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
      end
      S_DECODE: begin
        // branch/jal target is precomputed here into ALU_out
        ALU_src_A  = SRC_A_OLD_PC;
        ALU_src_B  = SRC_B_IMM;
        illegal_op = ~op_supported(op);
      end
      S_MEM_ADR: begin
        ALU_src_A = SRC_A_REG;
        ALU_src_B = SRC_B_IMM;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ALU_src_A = SRC_A_REG;
        ALU_op    = R_TYPE;
      end
      S_EXEC_I: begin
        ALU_src_A = SRC_A_REG;
        ALU_src_B = SRC_B_IMM;
        ALU_op    = I_TYPE;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALU_src_A = SRC_A_REG;
        ALU_op    = SUB_ANYWAY;
        PC_write  = ((f3 == F3_BEQ) &  zero) |
                    ((f3 == F3_BNE) & ~zero);
      end
      S_JAL: begin
        // PC takes the target from ALU_out while ALU computes old_PC+4 for rd
        ALU_src_A = SRC_A_OLD_PC;
        ALU_src_B = SRC_B_FOUR;
        PC_write  = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PC_write   = 1'b0;
      mem_write  = 1'b0;
      IR_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  // Immediate format straight from the opcode, independent of state
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LW, OP_I_ALU: imm_src = IMM_I;
      OP_SW:           imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI:          imm_src = IMM_U;
      default:         imm_src = 3'b000;
    endcase
  end

endmodule
